// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Mid-bit sampling on a synchronized line, one-cycle result pulses.
module uart_rx #(
  parameter int clk_per_bit = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       o_rx_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_rx_active
);

  // state   | meaning
  // IDLE    | line idle, waiting for rx_s low
  // START   | confirm start bit at its midpoint
  // DATA    | sample 8 data bits, LSB first
  // PARITY  | sample even-parity bit
  // STOP    | sample stop bit, publish byte and flags
  // RECOVER | stop was low; wait for line to return high
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  localparam logic [7:0] HALF = 8'((clk_per_bit - 1) / 2);
  localparam logic [7:0] LAST = 8'(clk_per_bit - 1);

  logic       sync1_q, rx_s_q;
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       parity_bad;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 8'd1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    parity_bad = par_q ^ (^shift_q);
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = 8'd0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d              = 8'd0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = S_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = 8'd0;
          par_d   = rx_s_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = 8'd0;
          data_d  = shift_q;
          valid_d = rx_s_q & ~parity_bad;
          perr_d  = parity_bad;
          ferr_d  = ~rx_s_q;
          state_d = rx_s_q ? S_IDLE : S_RECOVER;
        end
      end
      S_RECOVER: begin
        // A held-low break must not look like a fresh start bit.
        cnt_d = 8'd0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= serial_in;
      rx_s_q    <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data      = data_q;
  assign o_rx_valid   = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_rx_active  = (state_q != S_IDLE);

endmodule
